// File: rtl/calendar_date_counter.sv
// Day/month/year counter advanced by day_tick, with a validated four-state load handshake.
// Define CAL_LEAP_YEAR_EN to enable Gregorian leap years (29 Feb); otherwise February has 28 days.
module calendar_date_counter #(
    parameter int unsigned YEAR_MIN = 2000,
    parameter int unsigned YEAR_MAX = 2047
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        day_tick,
    input  logic        set_valid,
    input  logic [4:0]  set_day,
    input  logic [3:0]  set_month,
    input  logic [10:0] set_year,
    output logic        set_ack,
    output logic        set_err,
    output logic [4:0]  day,
    output logic [3:0]  month,
    output logic [10:0] year,
    output logic        year_stb,
    output logic        year_wrap
);
    localparam logic [10:0] YMIN = 11'(YEAR_MIN);
    localparam logic [10:0] YMAX = 11'(YEAR_MAX);

    typedef enum logic [1:0] {IDLE, CHECK, COMMIT, WAIT_LOW} state_t;
    state_t state, state_nxt;

    logic [4:0]  sh_day;
    logic [3:0]  sh_month;
    logic [10:0] sh_year;
    logic        valid_r, valid_nxt;
    logic        tick_pend, tick_pend_nxt;
    logic        accept;
    logic [4:0]  adv_day;
    logic [3:0]  adv_month;
    logic [10:0] adv_year;
    logic        adv_stb, adv_wrap;

    function automatic logic leap(input logic [10:0] y);
`ifdef CAL_LEAP_YEAR_EN
        return (y[1:0] == 2'd0) && ((y % 11'd100 != 11'd0) || (y % 11'd400 == 11'd0));
`else
        return &{1'b0, y};
`endif
    endfunction

    function automatic logic [4:0] dim(input logic [3:0] m, input logic [10:0] y);
        case (m)
            4'd2:                    return leap(y) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            default:                 return 5'd31;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (set_valid) state_nxt = CHECK;
            CHECK:    state_nxt = COMMIT;
            COMMIT:   state_nxt = WAIT_LOW;
            WAIT_LOW: if (!set_valid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // A tick coinciding with a pending one in WAIT_LOW is held over one cycle rather than lost.
    always_comb begin
        accept        = ((state == IDLE) || (state == WAIT_LOW)) && (day_tick || tick_pend);
        tick_pend_nxt = tick_pend & day_tick;
        if ((state == CHECK) || (state == COMMIT))
            tick_pend_nxt = tick_pend | day_tick;
    end

    always_comb begin
        valid_nxt = (sh_month >= 4'd1) && (sh_month <= 4'd12) &&
                    (sh_day != 5'd0) && (sh_day <= dim(sh_month, sh_year)) &&
                    (sh_year >= YMIN) && (sh_year <= YMAX);
    end

    always_comb begin
        adv_day   = day + 5'd1;
        adv_month = month;
        adv_year  = year;
        adv_stb   = 1'b0;
        adv_wrap  = 1'b0;
        if (day >= dim(month, year)) begin
            adv_day = 5'd1;
            if (month < 4'd12) begin
                adv_month = month + 4'd1;
            end else begin
                adv_month = 4'd1;
                adv_stb   = 1'b1;
                if (year == YMAX) begin
                    adv_year = YMIN;
                    adv_wrap = 1'b1;
                end else begin
                    adv_year = year + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sh_day    <= '0;
            sh_month  <= '0;
            sh_year   <= '0;
            valid_r   <= 1'b0;
            tick_pend <= 1'b0;
            day       <= 5'd1;
            month     <= 4'd1;
            year      <= YMIN;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            year_stb  <= 1'b0;
            year_wrap <= 1'b0;
        end else begin
            state     <= state_nxt;
            tick_pend <= tick_pend_nxt;
            set_ack   <= 1'b0;
            set_err   <= 1'b0;
            year_stb  <= 1'b0;
            year_wrap <= 1'b0;
            if ((state == IDLE) && set_valid) begin
                sh_day   <= set_day;
                sh_month <= set_month;
                sh_year  <= set_year;
            end
            if (state == CHECK)
                valid_r <= valid_nxt;
            if (state == COMMIT) begin
                set_ack <= 1'b1;
                set_err <= !valid_r;
                if (valid_r) begin
                    day      <= sh_day;
                    month    <= sh_month;
                    year     <= sh_year;
                    year_stb <= (sh_year != year);
                end
            end else if (accept) begin
                day       <= adv_day;
                month     <= adv_month;
                year      <= adv_year;
                year_stb  <= adv_stb;
                year_wrap <= adv_wrap;
            end
        end
    end
endmodule

// File: tb/tb_calendar_date_counter.sv
// Self-checking bench for calendar_date_counter: directed test-plan steps plus randomized
// ticks/loads checked against an ordinal-day calendar model. Honours CAL_LEAP_YEAR_EN.
`timescale 1ns/1ps
module tb_calendar_date_counter;
    localparam int YMIN = 2000;
    localparam int YMAX = 2047;

    logic        clk = 1'b0;
    logic        rst, day_tick, set_valid;
    logic [4:0]  set_day;
    logic [3:0]  set_month;
    logic [10:0] set_year;
    logic        set_ack, set_err, year_stb, year_wrap;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [10:0] year;

    always #5 clk = ~clk;

    calendar_date_counter #(.YEAR_MIN(YMIN), .YEAR_MAX(YMAX)) dut (
        .clk(clk), .rst(rst), .day_tick(day_tick), .set_valid(set_valid),
        .set_day(set_day), .set_month(set_month), .set_year(set_year),
        .set_ack(set_ack), .set_err(set_err), .day(day), .month(month),
        .year(year), .year_stb(year_stb), .year_wrap(year_wrap)
    );

    int   n_vec = 0;
    int   n_err = 0;
    int   md, mm, my;
    logic e_stb, e_wrap;

    function automatic bit is_leap(int y);
`ifdef CAL_LEAP_YEAR_EN
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
        return 1'b0;
`endif
    endfunction

    function automatic int mdays(int m, int y);
        case (m)
            2:           return is_leap(y) ? 29 : 28;
            4, 6, 9, 11: return 30;
            default:     return 31;
        endcase
    endfunction

    function automatic int ydays(int y);
        return is_leap(y) ? 366 : 365;
    endfunction

    // Date as a day index counted from 1 Jan YMIN.
    function automatic int to_ord(int d, int m, int y);
        int o = 0;
        for (int yy = YMIN; yy < y; yy++) o += ydays(yy);
        for (int mo = 1; mo < m; mo++) o += mdays(mo, y);
        return o + d - 1;
    endfunction

    task automatic from_ord(input int o, output int d, output int m, output int y);
        y = YMIN;
        while (o >= ydays(y)) begin o -= ydays(y); y++; end
        m = 1;
        while (o >= mdays(m, y)) begin o -= mdays(m, y); m++; end
        d = o + 1;
    endtask

    task automatic m_tick();
        int o, nd, nm, ny;
        o = (to_ord(md, mm, my) + 1) % to_ord(1, 1, YMAX + 1);
        from_ord(o, nd, nm, ny);
        e_stb  = (ny != my);
        e_wrap = (o == 0);
        md = nd; mm = nm; my = ny;
    endtask

    task automatic m_reset();
        md = 1; mm = 1; my = YMIN; e_stb = 1'b0; e_wrap = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic ack_e, input logic err_e);
        chk({tag, ".day"},   32'(day),       32'(md));
        chk({tag, ".month"}, 32'(month),     32'(mm));
        chk({tag, ".year"},  32'(year),      32'(my));
        chk({tag, ".stb"},   32'(year_stb),  32'(e_stb));
        chk({tag, ".wrap"},  32'(year_wrap), 32'(e_wrap));
        chk({tag, ".ack"},   32'(set_ack),   32'(ack_e));
        chk({tag, ".err"},   32'(set_err),   32'(err_e));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_cycle(input logic t);
        day_tick = t;
        step();
        day_tick = 1'b0;
        if (t) m_tick();
        else begin e_stb = 1'b0; e_wrap = 1'b0; end
        check_state("tick", 1'b0, 1'b0);
    endtask

    task automatic do_load(input string tag, input int d, input int m, input int y, input logic tck);
        logic ok;
        ok = (m >= 1) && (m <= 12) && (d >= 1) && (y >= YMIN) && (y <= YMAX);
        if (ok) ok = (d <= mdays(m, y));
        set_day = 5'(d); set_month = 4'(m); set_year = 11'(y);
        set_valid = 1'b1;
        step();
        e_stb = 1'b0; e_wrap = 1'b0;
        check_state({tag, ".latch"}, 1'b0, 1'b0);
        day_tick = tck;
        step();
        day_tick = 1'b0;
        check_state({tag, ".check"}, 1'b0, 1'b0);
        step();
        e_stb = 1'b0; e_wrap = 1'b0;
        if (ok) begin
            e_stb = (y != my);
            md = d; mm = m; my = y;
        end
        check_state({tag, ".commit"}, 1'b1, !ok);
        set_valid = 1'b0;
        step();
        if (tck) m_tick();
        else begin e_stb = 1'b0; e_wrap = 1'b0; end
        check_state({tag, ".waitlow"}, 1'b0, 1'b0);
    endtask

    initial begin
        int acks, r, m, y;
        rst = 1'b1; day_tick = 1'b0; set_valid = 1'b0;
        set_day = '0; set_month = '0; set_year = '0;
        m_reset();
        #12;
        check_state("reset", 1'b0, 1'b0);
        rst = 1'b0;

        repeat (31) tick_cycle(1'b1);
        chk("feb1.day", 32'(day), 1);
        chk("feb1.month", 32'(month), 2);
        repeat (28) tick_cycle(1'b1);
`ifdef CAL_LEAP_YEAR_EN
        chk("feb29.day", 32'(day), 29);
        chk("feb29.month", 32'(month), 2);
`else
        chk("mar1.day", 32'(day), 1);
        chk("mar1.month", 32'(month), 3);
`endif

        do_load("dec31", 31, 12, 2047, 1'b0);
        tick_cycle(1'b1);
        chk("wrap.stb", 32'(year_stb), 1);
        chk("wrap.flag", 32'(year_wrap), 1);
        chk("wrap.year", 32'(year), 2000);

        do_load("apr31", 31, 4, 2010, 1'b0);
        do_load("mon13", 1, 13, 2010, 1'b0);
        do_load("y1999", 1, 1, 1999, 1'b0);
        do_load("feb29_2001", 29, 2, 2001, 1'b0);
        do_load("feb28_2004_tick", 28, 2, 2004, 1'b1);

        // Reset while the request is in CHECK: nothing may be committed.
        set_day = 5'd15; set_month = 4'd6; set_year = 11'd2030;
        set_valid = 1'b1;
        step();
        rst = 1'b1;
        set_valid = 1'b0;
        #1;
        m_reset();
        check_state("rst_mid.async", 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
        repeat (3) begin
            step();
            check_state("rst_mid.after", 1'b0, 1'b0);
        end

        // set_valid held high: one ack, then another only after a low cycle.
        set_day = 5'd10; set_month = 4'd10; set_year = 11'd2020;
        set_valid = 1'b1;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (set_ack) acks++;
        end
        chk("hold.acks", 32'(acks), 1);
        md = 10; mm = 10; my = 2020; e_stb = 1'b0; e_wrap = 1'b0;
        check_state("hold.end", 1'b0, 1'b0);
        set_valid = 1'b0;
        step();
        set_valid = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (set_ack) acks++;
        end
        chk("rehold.acks", 32'(acks), 1);
        set_valid = 1'b0;
        step();
        check_state("rehold.end", 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 2);
            if (r == 0) begin
                repeat ($urandom_range(1, 60)) tick_cycle(1'($urandom_range(0, 1)));
            end else if (r == 1) begin
                do_load("rnd_load", $urandom_range(0, 31), $urandom_range(0, 15),
                        $urandom_range(YMIN - 2, YMAX + 2), 1'($urandom_range(0, 1)));
            end else begin
                m = $urandom_range(1, 12);
                y = ($urandom_range(0, 3) == 0) ? YMAX : $urandom_range(YMIN, YMAX);
                if ($urandom_range(0, 1) == 1) m = 12;
                do_load("rnd_edge", mdays(m, y), m, y, 1'($urandom_range(0, 1)));
                repeat (3) tick_cycle(1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
